// File: rtl/bcd_seg_display.sv
// bcd_seg_display: sequential binary-to-seven-segment display engine.
// Converts a W_DATA-bit signed/unsigned operand into N_DIGITS BCD digits
// using one double-dabble shift per clock, then registers active-low
// segment codes plus a separate sign digit.
// Optional feature macro: BCD_SEG_DISPLAY_LZB_EN (leading-zero blanking).
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for start_i; display holds the last result
// PROCESING | W_DATA double-dabble shifts, one per clock
// READY     | one cycle; its exit edge registers the display and ready_o
// CLEAR     | one cycle; its exit edge blanks the display and drops ovf_o
module bcd_seg_display #(
  parameter int W_DATA   = 16,
  parameter int N_DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  clear_i,
  input  logic                  signed_i,
  input  logic [W_DATA-1:0]     data_i,
  output logic                  busy_o,
  output logic                  ready_o,
  output logic                  ovf_o,
  output logic [6:0]            sign_seg_o,
  output logic [7*N_DIGITS-1:0] seg_o
);

  localparam int NB = N_DIGITS + 1;        // extra top nibble flags overflow
  localparam int BW = 4 * NB;
  localparam int CW = $clog2(W_DATA + 1);

  typedef enum logic [1:0] {IDLE, PROCESING, READY, CLEAR} state_e;

  typedef enum logic [6:0] {
    ZERO  = 7'b1000000,
    ONE   = 7'b1111001,
    TWO   = 7'b0100100,
    TREE  = 7'b0110000,
    FOUR  = 7'b0011001,
    FIVE  = 7'b0010010,
    SIX   = 7'b0000010,
    SEVEN = 7'b1111000,
    EIGHT = 7'b0000000,
    NINE  = 7'b0010000,
    SIGN  = 7'b0111111,
    OFF   = 7'b1111111
  } sgmnt_e;

  state_e                 state, state_nxt;
  logic [W_DATA-1:0]      mag;
  logic [BW-1:0]          bcd, bcd_adj;
  logic [CW-1:0]          cnt;
  logic                   neg;
  logic                   ovf_acc;
  logic                   ovf_now;
  logic [7*N_DIGITS-1:0]  seg_next;
  logic [6:0]             sign_q;
  logic [7*N_DIGITS-1:0]  seg_q;
  logic                   ovf_q;
  logic                   ready_q;

  function automatic logic [6:0] nib2seg(input logic [3:0] n);
    logic [6:0] code;
    case (n)
      4'd0:    code = ZERO;
      4'd1:    code = ONE;
      4'd2:    code = TWO;
      4'd3:    code = TREE;
      4'd4:    code = FOUR;
      4'd5:    code = FIVE;
      4'd6:    code = SIX;
      4'd7:    code = SEVEN;
      4'd8:    code = EIGHT;
      4'd9:    code = NINE;
      default: code = OFF;
    endcase
    return code;
  endfunction

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; clear_i overrides everything, including start_i
  always_comb begin
    state_nxt = state;
    if (clear_i) begin
      state_nxt = CLEAR;
    end else begin
      case (state)
        IDLE:      if (start_i) state_nxt = PROCESING;
        PROCESING: if (cnt == CW'(W_DATA)) state_nxt = READY;
        READY:     state_nxt = IDLE;
        CLEAR:     state_nxt = IDLE;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    busy_o = (state == PROCESING) || (state == READY);
  end

  // Double-dabble correction: add 3 to every nibble that is 5 or more
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < NB; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Any non-zero top nibble seen during or after the shifts means the
  // magnitude cannot fit in N_DIGITS digits
  assign ovf_now = ovf_acc | (|bcd[BW-1 -: 4]);

  // Digit codes presented to the display register on the READY exit edge
  always_comb begin
`ifdef BCD_SEG_DISPLAY_LZB_EN
    logic lead;
    lead = 1'b1;
`endif
    seg_next = '1;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      if (ovf_now) begin
        seg_next[7*i +: 7] = SIGN;
`ifdef BCD_SEG_DISPLAY_LZB_EN
      end else if (lead && (bcd[4*i +: 4] == 4'd0) && (i != 0)) begin
        seg_next[7*i +: 7] = OFF;
      end else begin
        seg_next[7*i +: 7] = nib2seg(bcd[4*i +: 4]);
        lead = 1'b0;
      end
`else
      end else begin
        seg_next[7*i +: 7] = nib2seg(bcd[4*i +: 4]);
      end
`endif
    end
  end

  // Conversion datapath: operand capture and shift/add iteration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag     <= '0;
      bcd     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      ovf_acc <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i && !clear_i) begin
            // A set MSB in signed mode implies a non-zero magnitude, so the
            // sign flag can never describe a negative zero.
            neg     <= signed_i & data_i[W_DATA-1];
            mag     <= (signed_i & data_i[W_DATA-1]) ?
                       (~data_i) + {{(W_DATA-1){1'b0}}, 1'b1} : data_i;
            bcd     <= '0;
            cnt     <= '0;
            ovf_acc <= 1'b0;
          end
        end
        PROCESING: begin
          if (cnt != CW'(W_DATA)) begin
            bcd     <= {bcd_adj[BW-2:0], mag[W_DATA-1]};
            mag     <= {mag[W_DATA-2:0], 1'b0};
            cnt     <= cnt + CW'(1);
            ovf_acc <= ovf_acc | (|bcd_adj[BW-1 -: 4]);
          end
        end
        default: ;
      endcase
    end
  end

  // Display registers: loaded on READY exit, blanked on CLEAR exit, else held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_q   <= '1;
      sign_q  <= OFF;
      ovf_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      if (state == READY && !clear_i) begin
        seg_q   <= seg_next;
        sign_q  <= neg ? SIGN : OFF;
        ovf_q   <= ovf_now;
        ready_q <= 1'b1;
      end else if (state == CLEAR) begin
        seg_q   <= '1;
        sign_q  <= OFF;
        ovf_q   <= 1'b0;
      end
    end
  end

  assign seg_o      = seg_q;
  assign sign_seg_o = sign_q;
  assign ovf_o      = ovf_q;
  assign ready_o    = ready_q;

endmodule
